fifo_frame_reader: RTL and testbench

Read-side drain engine for the switch's packet-data FIFO. It pops beats from a `fifo` instance and replays them as byte-stream frames on a valid/ready transmit interface toward the egress MAC. Between frames it enforces a minimum idle gap, and it truncates runaway frames. It is the consumer counterpart of the ingress logic that writes frames into the FIFO.

---
 rtl/fifo_frame_reader.sv | 173 +++++++++++++++++
 tb/tb_fifo_frame_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_reader.sv
// Drains framed beats from the packet-data FIFO onto a valid/ready byte stream,
// enforcing an inter-frame idle gap and truncating frames longer than MAX_BEATS.
module fifo_frame_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int GAP_CYCLES  = 12,
    parameter int MAX_BEATS   = 1518,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH:0]    fifo_read_data,
    output logic                   fifo_read_enable,
    input  logic                   fifo_is_empty,
    output logic [DATA_WIDTH-1:0]  tx_data,
    output logic                   tx_last,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic [COUNT_WIDTH-1:0] truncated_count,
    output logic                   busy
);
    localparam int BEAT_W = $clog2(MAX_BEATS);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BEATS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, STREAM, DISCARD, GAP} state_t;

    state_t                 state_reg, state_next;
    logic [DATA_WIDTH:0]    buf_reg [2];
    logic [DATA_WIDTH:0]    buf_next [2];
    logic [1:0]             count_reg, count_next, count_after_pop;
    logic                   inflight_reg;
    logic [BEAT_W-1:0]      beat_cnt_reg, beat_cnt_next;
    logic [GAP_W-1:0]       gap_cnt_reg, gap_cnt_next;
    logic                   tx_valid_reg, tx_valid_next;
    logic                   tx_last_reg, tx_last_next;
    logic [COUNT_WIDTH-1:0] frame_count_reg, frame_count_next;
    logic [COUNT_WIDTH-1:0] truncated_count_reg, truncated_count_next;
    logic                   busy_reg, busy_next;
    logic                   accept, drop, pop, head_marker, frame_end;

    // Occupancy counts the entry leaving this cycle, so a full-rate stream never bubbles.
    always_comb begin
        accept           = tx_valid_reg && tx_ready;
        drop             = (state_reg == DISCARD) && (count_reg != 2'd0);
        pop              = accept || drop;
        head_marker      = buf_reg[0][DATA_WIDTH];
        count_after_pop  = count_reg - {1'b0, pop};
        fifo_read_enable = reset && !fifo_is_empty
                           && ((count_after_pop + {1'b0, inflight_reg}) < 2'd2);

        buf_next = buf_reg;
        if (pop) begin
            buf_next[0] = buf_reg[1];
        end
        if (inflight_reg) begin
            buf_next[count_after_pop[0]] = fifo_read_data;
        end
        count_next = count_after_pop + {1'b0, inflight_reg};
    end

    always_comb begin
        state_next           = state_reg;
        beat_cnt_next        = beat_cnt_reg;
        gap_cnt_next         = gap_cnt_reg;
        frame_count_next     = frame_count_reg;
        truncated_count_next = truncated_count_reg;
        frame_end            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (head_marker) begin
                        frame_count_next = frame_count_reg + COUNT_WIDTH'(1);
                        frame_end        = 1'b1;
                    end else begin
                        state_next    = STREAM;
                        beat_cnt_next = BEAT_W'(1);
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    if (beat_cnt_reg == BEAT_LAST) begin
                        frame_count_next     = frame_count_reg + COUNT_WIDTH'(1);
                        truncated_count_next = truncated_count_reg + COUNT_WIDTH'(1);
                        beat_cnt_next        = '0;
                        if (head_marker) begin
                            frame_end = 1'b1;
                        end else begin
                            state_next = DISCARD;
                        end
                    end else if (head_marker) begin
                        frame_count_next = frame_count_reg + COUNT_WIDTH'(1);
                        beat_cnt_next    = '0;
                        frame_end        = 1'b1;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                    end
                end
            end
            DISCARD: begin
                if (drop && head_marker) begin
                    frame_end = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if (frame_end) begin
            state_next   = (GAP_CYCLES == 0) ? IDLE : GAP;
            gap_cnt_next = '0;
        end

        // Presentation is computed one cycle ahead so every tx output is a plain flop.
        tx_valid_next = ((state_next == IDLE) || (state_next == STREAM)) && (count_next != 2'd0);
        tx_last_next  = buf_next[0][DATA_WIDTH]
                        || ((state_next == STREAM) && (beat_cnt_next == BEAT_LAST));
        busy_next     = (state_next != IDLE) || (count_next != 2'd0) || fifo_read_enable;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                buf_reg[gi] <= '0;
            end else begin
                buf_reg[gi] <= buf_next[gi];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg           <= IDLE;
            count_reg           <= '0;
            inflight_reg        <= 1'b0;
            beat_cnt_reg        <= '0;
            gap_cnt_reg         <= '0;
            tx_valid_reg        <= 1'b0;
            tx_last_reg         <= 1'b0;
            frame_count_reg     <= '0;
            truncated_count_reg <= '0;
            busy_reg            <= 1'b0;
        end else begin
            state_reg           <= state_next;
            count_reg           <= count_next;
            inflight_reg        <= fifo_read_enable;
            beat_cnt_reg        <= beat_cnt_next;
            gap_cnt_reg         <= gap_cnt_next;
            tx_valid_reg        <= tx_valid_next;
            tx_last_reg         <= tx_last_next;
            frame_count_reg     <= frame_count_next;
            truncated_count_reg <= truncated_count_next;
            busy_reg            <= busy_next;
        end
    end

    assign tx_data         = buf_reg[0][DATA_WIDTH-1:0];
    assign tx_last         = tx_last_reg;
    assign tx_valid        = tx_valid_reg;
    assign frame_count     = frame_count_reg;
    assign truncated_count = truncated_count_reg;
    assign busy            = busy_reg;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader: behavioural FIFO, negedge monitor,
// hand-written expected beat sequences, gaps and counter values.
module tb_fifo_frame_reader;
    localparam int DW   = 8;
    localparam int GAP  = 3;
    localparam int MAXB = 4;
    localparam int CW   = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW:0]   fifo_read_data = '0;
    logic          fifo_read_enable;
    logic          fifo_is_empty = 1'b1;
    logic [DW-1:0] tx_data;
    logic          tx_last;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] truncated_count;
    logic          busy;

    fifo_frame_reader #(
        .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .MAX_BEATS(MAXB), .COUNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .fifo_read_data(fifo_read_data), .fifo_read_enable(fifo_read_enable),
        .fifo_is_empty(fifo_is_empty),
        .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .frame_count(frame_count), .truncated_count(truncated_count), .busy(busy)
    );

    always #5 clock = ~clock;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [DW:0] fq[$];
    int          rx_word[$];
    int          rx_cyc[$];
    int          exp_q[$];
    int          first_pop = -1;
    int          first_valid = -1;
    int          pops = 0;
    int          accs = 0;
    int          max_out = 0;
    bit          viol = 1'b0;
    bit          stab_err = 1'b0;
    bit          stab_en = 1'b1;
    bit          prev_stall = 1'b0;
    logic [DW:0] prev_beat = '0;

    // Behavioural FIFO: pop on the edge, data valid the following cycle.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (fifo_read_enable && fq.size() > 0) begin
            fifo_read_data <= fq.pop_front();
        end
        fifo_is_empty <= (fq.size() == 0);
    end

    always @(negedge clock) begin
        if (fifo_read_enable && fifo_is_empty) viol = 1'b1;
        if (fifo_read_enable && !fifo_is_empty) begin
            pops++;
            if (first_pop < 0) first_pop = cyc;
        end
        if (tx_valid && first_valid < 0) first_valid = cyc;
        if (tx_valid && tx_ready) begin
            accs++;
            rx_word.push_back(int'({tx_last, tx_data}));
            rx_cyc.push_back(cyc);
            $display("beat cyc=%0d data=0x%02h last=%0d", cyc, tx_data, tx_last);
        end
        if (pops - accs > max_out) max_out = pops - accs;
        if (stab_en && prev_stall && !(tx_valid && {tx_last, tx_data} == prev_beat)) stab_err = 1'b1;
        prev_stall = tx_valid && !tx_ready;
        prev_beat  = {tx_last, tx_data};
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic loadf(input int first, input int n);
        logic [DW:0] w;
        for (int i = 0; i < n; i++) begin
            w = {(i == n - 1), DW'(first + i)};
            fq.push_back(w);
        end
    endtask

    task automatic expf(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(((i == n - 1) ? (1 << DW) : 0) + first + i);
        end
    endtask

    task automatic clear();
        rx_word.delete();
        rx_cyc.delete();
        exp_q.delete();
        first_pop   = -1;
        first_valid = -1;
        pops        = 0;
        accs        = 0;
        max_out     = 0;
    endtask

    task automatic wait_rx(input int n, input string tag);
        int b = 0;
        while (rx_word.size() < n && b < 200) begin
            step(1);
            b++;
        end
        if (rx_word.size() < n) chk(tag, rx_word.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int b = 0;
        while (busy && b < 100) begin
            step(1);
            b++;
        end
        step(2);
        if (busy) chk(tag, int'(busy), 0);
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_len"}, rx_word.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), (i < rx_word.size()) ? rx_word[i] : -1, exp_q[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, int'(tx_valid), 0);
        chk({tag, "_data"},  int'(tx_data), 0);
        chk({tag, "_last"},  int'(tx_last), 0);
        chk({tag, "_rden"},  int'(fifo_read_enable), 0);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_frames"}, int'(frame_count), 0);
        chk({tag, "_trunc"},  int'(truncated_count), 0);
    endtask

    initial begin
        int b;
        #1 reset = 1'b0;
        #1 check_reset_outputs("rst");
        @(posedge clock); #1 reset = 1'b1;
        step(2);

        // Basic 3-beat frame at full rate.
        clear();
        loadf(1, 3);
        expf(1, 3);
        wait_rx(3, "basic_timeout");
        wait_idle("basic_idle");
        check_seq("basic");
        chk("basic_latency", first_valid - first_pop, 2);
        chk("basic_rate01", rx_cyc[1] - rx_cyc[0], 1);
        chk("basic_rate12", rx_cyc[2] - rx_cyc[1], 1);
        chk("basic_frames", int'(frame_count), 1);
        chk("basic_trunc", int'(truncated_count), 0);

        // Back-pressure with tx_ready toggling every cycle.
        clear();
        tx_ready = 1'b0;
        loadf('h11, 3);
        expf('h11, 3);
        b = 0;
        while (rx_word.size() < 3 && b < 60) begin
            step(1);
            tx_ready = ~tx_ready;
            b++;
        end
        tx_ready = 1'b1;
        if (rx_word.size() < 3) chk("bp_timeout", rx_word.size(), 3);
        wait_idle("bp_idle");
        check_seq("bp");
        chk("bp_stable", int'(stab_err), 0);
        chk("bp_max_buffered", int'(max_out <= 2), 1);
        chk("bp_frames", int'(frame_count), 2);

        // Two pre-loaded 2-beat frames: exact idle gap between them.
        clear();
        loadf('h31, 2);
        loadf('h33, 2);
        expf('h31, 2);
        expf('h33, 2);
        wait_rx(4, "gap_timeout");
        wait_idle("gap_idle");
        check_seq("gap");
        chk("gap_cycles", rx_cyc[2] - rx_cyc[1] - 1, GAP);
        chk("gap_frames", int'(frame_count), 4);

        // 6-beat frame truncated at 4, tail dropped, then a 1-beat frame.
        clear();
        loadf(1, 6);
        loadf(9, 1);
        expf(1, 4);
        expf(9, 1);
        wait_rx(5, "trunc_timeout");
        wait_idle("trunc_idle");
        check_seq("trunc");
        chk("trunc_frames", int'(frame_count), 6);
        chk("trunc_count", int'(truncated_count), 1);
        chk("trunc_gap_min", int'(rx_cyc[4] - rx_cyc[3] - 1 >= 2 + GAP), 1);
        chk("trunc_fifo_drained", fq.size(), 0);

        // Marker lands exactly on beat MAX_BEATS: no discard.
        clear();
        loadf('h41, 4);
        loadf('h45, 1);
        expf('h41, 4);
        expf('h45, 1);
        wait_rx(5, "maxm_timeout");
        wait_idle("maxm_idle");
        check_seq("maxm");
        chk("maxm_gap", rx_cyc[4] - rx_cyc[3] - 1, GAP);
        chk("maxm_frames", int'(frame_count), 8);
        chk("maxm_trunc", int'(truncated_count), 2);

        // Reset while beat 2 of 5 is stalled on the output.
        clear();
        stab_en = 1'b0;
        loadf('h21, 5);
        b = 0;
        while (rx_word.size() < 1 && b < 50) begin
            step(1);
            b++;
        end
        if (rx_word.size() < 1) chk("rstm_timeout", rx_word.size(), 1);
        tx_ready = 1'b0;
        step(6);
        chk("rstm_fifo_left", fq.size(), 2);
        chk("rstm_valid_pre", int'(tx_valid), 1);
        chk("rstm_data_pre", int'(tx_data), 'h22);
        #2 reset = 1'b0;
        #1 check_reset_outputs("rstm");
        step(2);
        reset = 1'b1;
        clear();
        tx_ready = 1'b1;
        expf('h24, 2);
        wait_rx(2, "rstm_timeout2");
        wait_idle("rstm_idle");
        check_seq("rstm");
        chk("rstm_frames", int'(frame_count), 1);
        chk("rstm_trunc", int'(truncated_count), 0);

        chk("no_read_when_empty", int'(viol), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
